// File: rtl/demux1to4_32_buf_if.sv
// Handshake bundle for the 1-to-4 registered distributor.
// master = word source + consumers, slave = distributor.
interface demux1to4_32_buf_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_c;
  logic [CNT_W-1:0] cnt_d;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid,
    input  out_a, out_b, out_c, out_d,
    input  cnt_a, cnt_b, cnt_c, cnt_d
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid,
    output out_a, out_b, out_c, out_d,
    output cnt_a, cnt_b, cnt_c, cnt_d
  );
endinterface

// File: rtl/demux1to4_32_buf.sv
// Registered 1-to-4 distributor: one-entry slot per channel, per-channel
// delivered counters. Ports: clk, rst_n (async low), bus (slave modport).
module demux1to4_32_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  demux1to4_32_buf_if.slave bus
);

  logic [WIDTH-1:0] slot [4];
  logic [CNT_W-1:0] cnt  [4];
  logic [3:0]       vld;
  logic [3:0]       drain;
  logic [3:0]       load;
  logic             in_ready;

  // Only the addressed slot can stall the source; a full slot that is
  // draining this edge can take a new word.
  assign in_ready = ~vld[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign drain    = vld & bus.out_ready;

  always_comb begin
    load = '0;
    if (bus.in_valid && in_ready)
      load[bus.in_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < 4; k++) begin
        slot[k] <= '0;
        cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k])
          slot[k] <= bus.in_data;
        if (drain[k])
          cnt[k] <= cnt[k] + CNT_W'(1);
        // refill wins over drain so throughput stays 1 word/cycle
        if (load[k])
          vld[k] <= 1'b1;
        else if (drain[k])
          vld[k] <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld;
  assign bus.out_a     = slot[0];
  assign bus.out_b     = slot[1];
  assign bus.out_c     = slot[2];
  assign bus.out_d     = slot[3];
  assign bus.cnt_a     = cnt[0];
  assign bus.cnt_b     = cnt[1];
  assign bus.cnt_c     = cnt[2];
  assign bus.cnt_d     = cnt[3];

endmodule

// File: tb/tb_demux1to4_32_buf.sv
// Scoreboard bench for demux1to4_32_buf (main instance CNT_W=16,
// second instance CNT_W=4 for counter wrap).
module tb_demux1to4_32_buf;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux1to4_32_buf_if #(.WIDTH(32), .CNT_W(16)) ifa ();
  demux1to4_32_buf_if #(.WIDTH(32), .CNT_W(4))  ifw ();

  demux1to4_32_buf #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );

  demux1to4_32_buf #(.WIDTH(32), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(ifw.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] q [4][$];
  logic [15:0] cnt_m [4];

  function automatic logic [31:0] outd(input int k);
    case (k)
      0: return ifa.out_a;
      1: return ifa.out_b;
      2: return ifa.out_c;
      default: return ifa.out_d;
    endcase
  endfunction

  function automatic logic [15:0] cntd(input int k);
    case (k)
      0: return ifa.cnt_a;
      1: return ifa.cnt_b;
      2: return ifa.cnt_c;
      default: return ifa.cnt_d;
    endcase
  endfunction

  // Inputs change at posedge+1, so the negedge sees what the next edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        cnt_m[k] = '0;
      end
    end else begin
      logic exp_rdy;
      exp_rdy = (q[ifa.in_sel].size() == 0) || ifa.out_ready[ifa.in_sel];
      checks++;
      if (ifa.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL sb_in_ready sel=%0d got %b exp %b",
                 ifa.in_sel, ifa.in_ready, exp_rdy);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ifa.out_valid[k] !== (q[k].size() != 0)) begin
          errors++;
          $display("FAIL sb_valid ch%0d got %b exp %b",
                   k, ifa.out_valid[k], q[k].size() != 0);
        end
        if (q[k].size() != 0) begin
          checks++;
          if (outd(k) !== q[k][0]) begin
            errors++;
            $display("FAIL sb_data ch%0d got %h exp %h", k, outd(k), q[k][0]);
          end
        end
        checks++;
        if (cntd(k) !== cnt_m[k]) begin
          errors++;
          $display("FAIL sb_cnt ch%0d got %0d exp %0d", k, cntd(k), cnt_m[k]);
        end
        if (ifa.out_ready[k] && q[k].size() != 0) begin
          void'(q[k].pop_front());
          cnt_m[k] = cnt_m[k] + 16'd1;
        end
      end
      if (ifa.in_valid && exp_rdy)
        q[ifa.in_sel].push_back(ifa.in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [31:0] d);
    ifa.in_valid = 1'b1;
    ifa.in_sel   = sel;
    ifa.in_data  = d;
  endtask

  task automatic test_reset();
    ifa.out_ready = 4'b0000;
    send(2'd0, 32'h5555_0000);
    tick();
    send(2'd1, 32'h5555_0001);
    tick();
    ifa.in_valid = 1'b0;
    ifw.in_valid = 1'b1;
    ifw.in_sel   = 2'd2;
    ifw.in_data  = 32'h7777_0002;
    tick();
    ifw.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifa.out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL rst_valid got %b exp 0000", ifa.out_valid);
    end
    checks++;
    if ({ifa.out_a, ifa.out_b, ifa.out_c, ifa.out_d} !== 128'd0) begin
      errors++;
      $display("FAIL rst_data got %h %h %h %h exp 0",
               ifa.out_a, ifa.out_b, ifa.out_c, ifa.out_d);
    end
    checks++;
    if ({ifa.cnt_a, ifa.cnt_b, ifa.cnt_c, ifa.cnt_d} !== 64'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d %0d %0d %0d exp 0",
               ifa.cnt_a, ifa.cnt_b, ifa.cnt_c, ifa.cnt_d);
    end
    checks++;
    if (ifw.out_valid !== 4'b0000 || ifw.out_c !== 32'd0) begin
      errors++;
      $display("FAIL rst_w got %b %h exp 0000 0", ifw.out_valid, ifw.out_c);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (ifa.out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL rst_post got %b exp 0000", ifa.out_valid);
    end
  endtask

  task automatic test_route();
    logic [31:0] d;
    ifa.out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      d = 32'h1111_1111 * (i + 1);
      send(2'(i), d);
      #1;
      checks++;
      if (ifa.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL route_ready%0d got %b exp 1", i, ifa.in_ready);
      end
      tick();
      checks++;
      if (ifa.out_valid[i] !== 1'b1 || outd(i) !== d) begin
        errors++;
        $display("FAIL route_out%0d got %b %h exp 1 %h",
                 i, ifa.out_valid[i], outd(i), d);
      end
    end
    ifa.in_valid = 1'b0;
    tick();
    checks++;
    if ({ifa.cnt_a, ifa.cnt_b, ifa.cnt_c, ifa.cnt_d} !== {4{16'd1}}) begin
      errors++;
      $display("FAIL route_cnt got %0d %0d %0d %0d exp 1 1 1 1",
               ifa.cnt_a, ifa.cnt_b, ifa.cnt_c, ifa.cnt_d);
    end
  endtask

  task automatic test_stall();
    logic [15:0] c_exp;
    c_exp = cnt_m[2] + 16'd1;
    ifa.out_ready = 4'b1101;
    send(2'd1, 32'hDEAD_BEEF);
    tick();
    send(2'd2, 32'hCAFE_F00D);
    #1;
    checks++;
    if (ifa.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_c_ready got %b exp 1", ifa.in_ready);
    end
    tick();
    ifa.in_valid = 1'b0;
    tick();
    checks++;
    if (ifa.out_valid[1] !== 1'b1 || ifa.out_b !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL stall_hold got %b %h exp 1 deadbeef",
               ifa.out_valid[1], ifa.out_b);
    end
    checks++;
    if (ifa.cnt_c !== c_exp) begin
      errors++;
      $display("FAIL stall_cnt_c got %0d exp %0d", ifa.cnt_c, c_exp);
    end
    send(2'd1, 32'h1234_5678);
    #1;
    checks++;
    if (ifa.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_b_ready got %b exp 0", ifa.in_ready);
    end
    tick();
    checks++;
    if (ifa.in_ready !== 1'b0 || ifa.out_b !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL stall_b_hold got %b %h exp 0 deadbeef",
               ifa.in_ready, ifa.out_b);
    end
    ifa.out_ready = 4'b1111;
    #1;
    checks++;
    if (ifa.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got %b exp 1", ifa.in_ready);
    end
    tick();
    ifa.in_valid = 1'b0;
    checks++;
    if (ifa.out_valid[1] !== 1'b1 || ifa.out_b !== 32'h1234_5678) begin
      errors++;
      $display("FAIL stall_third got %b %h exp 1 12345678",
               ifa.out_valid[1], ifa.out_b);
    end
    tick();
  endtask

  task automatic test_drain_fill();
    logic [15:0] c_exp;
    ifa.out_ready = 4'b0000;
    send(2'd0, 32'h0000_000A);
    tick();
    c_exp = cnt_m[0] + 16'd1;
    ifa.out_ready = 4'b0001;
    send(2'd0, 32'h0000_000B);
    tick();
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 4'b0000;
    #1;
    checks++;
    if (ifa.out_valid[0] !== 1'b1 || ifa.out_a !== 32'h0000_000B) begin
      errors++;
      $display("FAIL fill_out got %b %h exp 1 0000000b",
               ifa.out_valid[0], ifa.out_a);
    end
    checks++;
    if (ifa.cnt_a !== c_exp) begin
      errors++;
      $display("FAIL fill_cnt got %0d exp %0d", ifa.cnt_a, c_exp);
    end
    ifa.out_ready = 4'b1111;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    ifw.out_ready = 4'b1000;
    for (int i = 0; i < 17; i++) begin
      ifw.in_valid = 1'b1;
      ifw.in_sel   = 2'd3;
      ifw.in_data  = 32'(i);
      tick();
    end
    ifw.in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (ifw.cnt_d !== 4'd1) begin
      errors++;
      $display("FAIL wrap_cnt_d got %0d exp 1", ifw.cnt_d);
    end
    checks++;
    if ({ifw.cnt_a, ifw.cnt_b, ifw.cnt_c} !== 12'd0 ||
        ifw.out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL wrap_other got %0d %0d %0d %b exp 0 0 0 0000",
               ifw.cnt_a, ifw.cnt_b, ifw.cnt_c, ifw.out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      ifa.in_valid  = 1'($urandom_range(0, 1));
      ifa.in_sel    = 2'($urandom_range(0, 3));
      ifa.in_data   = $urandom;
      ifa.out_ready = 4'($urandom_range(0, 15));
      tick();
    end
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 4'b1111;
    tick();
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q[k].size() != 0 || ifa.out_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL rand_drain ch%0d got q=%0d v=%b exp 0 0",
                 k, q[k].size(), ifa.out_valid[k]);
      end
      checks++;
      if (cntd(k) !== cnt_m[k]) begin
        errors++;
        $display("FAIL rand_cnt ch%0d got %0d exp %0d", k, cntd(k), cnt_m[k]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.in_sel    = 2'd0;
    ifa.in_data   = '0;
    ifa.out_ready = 4'b0000;
    ifw.in_valid  = 1'b0;
    ifw.in_sel    = 2'd0;
    ifw.in_data   = '0;
    ifw.out_ready = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_route();
    test_stall();
    test_drain_fill();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
